// File: rtl/axis_bw_sink.sv
// -----------------------------------------------------------------------------
// axis_bw_sink
//
// Purpose: an AXI-Stream read-data sink that measures bandwidth. Software
// raises START_REG. The block then latches the burst count and the throttle
// setting, accepts NBURST_REG*(BURST_LENGTH+1) beats, and reports:
//   - how many beats it accepted,
//   - how many cycles passed from the first accepted beat to the last one,
//   - optionally, how many beats carried the wrong data.
//
// Optional feature macro: AXIS_BW_SINK_CHECK_EN
//   Defined   : each accepted beat is compared with its zero-extended beat
//               index, and ERR_REG counts the mismatches (saturating).
//   Undefined : no comparator is built and ERR_REG is tied to 0.
//
// Parameters:
//   DATA_WIDTH   - AXIS data width in bits
//   BURST_LENGTH - beats per burst minus 1
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset
//   s_axis_tvalid - upstream beat valid
//   s_axis_tdata  - upstream beat data
//   s_axis_tready - sink ready
//   START_REG     - level-sensitive run request
//   NBURST_REG    - number of bursts expected
//   THROTTLE_REG  - tready deassert period (0 = never deassert)
//   IDLE_REG      - high while idle
//   DONE_REG      - high once the run has finished
//   CYCLES_REG    - cycles from the first accepted beat to the last, inclusive
//   BEATS_REG     - accepted beats
//   ERR_REG       - data mismatch count
// -----------------------------------------------------------------------------
module axis_bw_sink #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  START_REG,
  input  logic [31:0]           NBURST_REG,
  input  logic [7:0]            THROTTLE_REG,
  output logic                  IDLE_REG,
  output logic                  DONE_REG,
  output logic [31:0]           CYCLES_REG,
  output logic [31:0]           BEATS_REG,
  output logic [31:0]           ERR_REG
);

  typedef enum logic [2:0] {
    IDLE_ST,
    LATCH_ST,
    WAIT_ST,
    RUN_ST,
    DONE_ST
  } state_t;

  localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] expected_q, expected_d;
  logic [7:0]  throttle_q, throttle_d;
  logic [7:0]  phase_q, phase_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] cycles_q, cycles_d;
  // Cycles elapsed since the first accepted beat. CYCLES_REG snapshots this
  // count on each accepted beat, so idle cycles after the last beat (for
  // example, before an aborted run stops) are never counted.
  logic [31:0] elapsed_q, elapsed_d;

  logic        throttled;
  logic        accept;
  logic [31:0] beats_inc;
  logic [31:0] elapsed_inc;

`ifdef AXIS_BW_SINK_CHECK_EN
  logic [31:0] err_q, err_d;
  logic        beat_bad;
`endif

  // The tready stall happens when phase equals the latched throttle value.
  // A throttle value of 0 disables stalling.
  assign throttled = (throttle_q != 8'd0) && (phase_q == throttle_q);

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state_q)
      // With nothing expected, WAIT_ST must not take a beat on its way to DONE_ST.
      WAIT_ST: s_axis_tready = (expected_q != 32'd0) && !throttled;
      RUN_ST:  s_axis_tready = !throttled;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign accept      = s_axis_tvalid && s_axis_tready;
  assign beats_inc   = (beats_q == SAT_MAX) ? beats_q : beats_q + 32'd1;
  assign elapsed_inc = (elapsed_q == SAT_MAX) ? elapsed_q : elapsed_q + 32'd1;

`ifdef AXIS_BW_SINK_CHECK_EN
  // A correct beat carries its own zero-based index, zero-extended.
  assign beat_bad = (s_axis_tdata != DATA_WIDTH'(beats_q));
`else
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
`endif

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    throttle_d = throttle_q;
    beats_d    = beats_q;
    cycles_d   = cycles_q;
    elapsed_d  = elapsed_q;
    // The phase counter runs freely and wraps from the throttle value back to 0.
    phase_d    = throttled ? 8'd0 : phase_q + 8'd1;
`ifdef AXIS_BW_SINK_CHECK_EN
    err_d      = err_q;
`endif

    unique case (state_q)
      IDLE_ST: begin
        if (START_REG) state_d = LATCH_ST;
      end

      LATCH_ST: begin
        throttle_d = THROTTLE_REG;
        expected_d = NBURST_REG * 32'(BURST_LENGTH + 1);
        beats_d    = 32'd0;
        cycles_d   = 32'd0;
        elapsed_d  = 32'd0;
        phase_d    = 8'd0;
`ifdef AXIS_BW_SINK_CHECK_EN
        err_d      = 32'd0;
`endif
        state_d    = WAIT_ST;
      end

      WAIT_ST, RUN_ST: begin
        if ((state_q == WAIT_ST) && (expected_q == 32'd0)) begin
          state_d = DONE_ST;
        end else begin
          // Time starts on the first accepted beat and then runs every cycle.
          if ((state_q == RUN_ST) || accept) elapsed_d = elapsed_inc;
          if (accept) begin
            beats_d  = beats_inc;
            cycles_d = elapsed_inc;
`ifdef AXIS_BW_SINK_CHECK_EN
            if (beat_bad && (err_q != SAT_MAX)) err_d = err_q + 32'd1;
`endif
          end
          if (!START_REG || (accept && (beats_inc == expected_q))) begin
            state_d = DONE_ST;
          end else if (accept) begin
            state_d = RUN_ST;
          end
        end
      end

      DONE_ST: begin
        if (!START_REG) state_d = IDLE_ST;
      end

      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE_ST;
      expected_q <= 32'd0;
      throttle_q <= 8'd0;
      phase_q    <= 8'd0;
      beats_q    <= 32'd0;
      cycles_q   <= 32'd0;
      elapsed_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      throttle_q <= throttle_d;
      phase_q    <= phase_d;
      beats_q    <= beats_d;
      cycles_q   <= cycles_d;
      elapsed_q  <= elapsed_d;
    end
  end

`ifdef AXIS_BW_SINK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_q <= 32'd0;
    else     err_q <= err_d;
  end
  assign ERR_REG = err_q;
`else
  assign ERR_REG = 32'd0;
`endif

  assign IDLE_REG   = (state_q == IDLE_ST);
  assign DONE_REG   = (state_q == DONE_ST);
  assign BEATS_REG  = beats_q;
  assign CYCLES_REG = cycles_q;

endmodule

// File: tb/tb_axis_bw_sink.sv
// -----------------------------------------------------------------------------
// tb_axis_bw_sink
//
// Purpose: self-checking bench for axis_bw_sink.
//   - Directed runs come from a table of settings and expected results.
//   - Randomized runs are checked against a cycle-count reference model.
//   - Reset, including reset in the middle of a run, is checked by hand.
//
// The reference model treats the block as a sequence of cycles counted from
// the first WAIT cycle:
//   - tready is low when k mod (T+1) == T (for nonzero T), and low throughout
//     when nothing is expected.
//   - CYCLES is the index of the last accepted beat minus the index of the
//     first, plus 1.
// -----------------------------------------------------------------------------
module tb_axis_bw_sink;
  localparam int DW = 64;
  localparam int BL = 7;
`ifdef AXIS_BW_SINK_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic          clk;
  logic          rst;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tready;
  logic          START_REG;
  logic [31:0]   NBURST_REG;
  logic [7:0]    THROTTLE_REG;
  logic          IDLE_REG;
  logic          DONE_REG;
  logic [31:0]   CYCLES_REG;
  logic [31:0]   BEATS_REG;
  logic [31:0]   ERR_REG;

  axis_bw_sink #(.DATA_WIDTH(DW), .BURST_LENGTH(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tready(s_axis_tready),
    .START_REG    (START_REG),
    .NBURST_REG   (NBURST_REG),
    .THROTTLE_REG (THROTTLE_REG),
    .IDLE_REG     (IDLE_REG),
    .DONE_REG     (DONE_REG),
    .CYCLES_REG   (CYCLES_REG),
    .BEATS_REG    (BEATS_REG),
    .ERR_REG      (ERR_REG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int nburst;
    int thr;
    int bad_idx;
    int drop;
    int beats;
    int cycles;
    int err;
  } vec_t;

  vec_t tab[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run: START, stream beats, check the result, release START.
  task automatic run_case(input string tag, input int nburst, input int thr, input int pct,
                          input int bad_idx, input int drop_after, input bit rand_data,
                          input bit use_tab, input int t_beats, input int t_cycles,
                          input int t_err);
    int  expc;
    int  mb;
    int  first;
    int  last;
    int  merr;
    int  k;
    bit  fin;
    bit  ready_e;
    int  e_beats;
    int  e_cycles;
    int  e_err;
    expc  = nburst * (BL + 1);
    mb    = 0;
    first = -1;
    last  = -1;
    merr  = 0;
    k     = 0;
    fin   = 1'b0;
    NBURST_REG    = nburst;
    THROTTLE_REG  = 8'(thr);
    START_REG     = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    step();  // now in LATCH
    check({tag, " tready_latch"}, {63'd0, s_axis_tready}, 64'd0);
    s_axis_tvalid = 1'b0;
    step();  // now in WAIT, k = 0
    while (!fin) begin
      if (k >= 3000) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s timeout: got %0d beats, expected %0d", tag, mb, expc);
        break;
      end
      if (drop_after >= 0 && mb == drop_after) begin
        START_REG     = 1'b0;
        s_axis_tvalid = 1'b0;
        step();
        break;
      end
      ready_e = (expc != 0) && !(thr != 0 && (k % (thr + 1)) == thr);
      s_axis_tvalid = ($urandom_range(99) < pct);
      s_axis_tdata  = {32'h0, mb};
      if (mb == bad_idx) s_axis_tdata = 64'hFF;
      if (rand_data && $urandom_range(5) == 0) s_axis_tdata = {$urandom, $urandom};
      #1;
      check({tag, " tready"}, {63'd0, s_axis_tready}, {63'd0, ready_e});
      if (s_axis_tvalid && ready_e) begin
        if (ERR_ON != 0 && s_axis_tdata != {32'h0, mb}) merr++;
        if (first < 0) first = k;
        last = k;
        mb++;
      end
      if (expc == 0 || mb == expc) fin = 1'b1;
      step();
      k++;
    end
    s_axis_tvalid = 1'b0;
    e_beats  = use_tab ? t_beats : mb;
    e_cycles = use_tab ? t_cycles : ((first < 0) ? 0 : last - first + 1);
    e_err    = use_tab ? t_err : merr;
    check({tag, " done"},   {63'd0, DONE_REG}, 64'd1);
    check({tag, " idle"},   {63'd0, IDLE_REG}, 64'd0);
    check({tag, " beats"},  {32'd0, BEATS_REG}, 64'(e_beats));
    check({tag, " cycles"}, {32'd0, CYCLES_REG}, 64'(e_cycles));
    check({tag, " err"},    {32'd0, ERR_REG}, 64'(e_err));
    // Beats offered while DONE must be ignored and the counters must hold.
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    step();
    check({tag, " tready_done"}, {63'd0, s_axis_tready}, 64'd0);
    step();
    check({tag, " beats_hold"}, {32'd0, BEATS_REG}, 64'(e_beats));
    START_REG     = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    check({tag, " back_idle"},  {63'd0, IDLE_REG}, 64'd1);
    check({tag, " cycles_hold"}, {32'd0, CYCLES_REG}, 64'(e_cycles));
    $display("run %s: nburst=%0d thr=%0d beats=%0d cycles=%0d err=%0d", tag, nburst, thr,
             BEATS_REG, CYCLES_REG, ERR_REG);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    START_REG     = 1'b0;
    NBURST_REG    = '0;
    THROTTLE_REG  = '0;
    step();
    step();
    check("reset tready", {63'd0, s_axis_tready}, 64'd0);
    check("reset idle",   {63'd0, IDLE_REG}, 64'd1);
    check("reset done",   {63'd0, DONE_REG}, 64'd0);
    check("reset beats",  {32'd0, BEATS_REG}, 64'd0);
    check("reset cycles", {32'd0, CYCLES_REG}, 64'd0);
    check("reset err",    {32'd0, ERR_REG}, 64'd0);
    rst = 1'b0;
    step();

    tab[0] = '{nburst: 4, thr: 0, bad_idx: -1, drop: -1, beats: 32, cycles: 32, err: 0};
    tab[1] = '{nburst: 2, thr: 3, bad_idx: -1, drop: -1, beats: 16, cycles: 21, err: 0};
    tab[2] = '{nburst: 0, thr: 0, bad_idx: -1, drop: -1, beats: 0,  cycles: 0,  err: 0};
    tab[3] = '{nburst: 1, thr: 0, bad_idx: 5,  drop: -1, beats: 8,  cycles: 8,  err: ERR_ON};
    tab[4] = '{nburst: 2, thr: 0, bad_idx: -1, drop: 3,  beats: 3,  cycles: 3,  err: 0};
    tab[5] = '{nburst: 1, thr: 1, bad_idx: -1, drop: -1, beats: 8,  cycles: 15, err: 0};
    tab[6] = '{nburst: 3, thr: 7, bad_idx: -1, drop: -1, beats: 24, cycles: 27, err: 0};

    for (int i = 0; i < 7; i++) begin
      run_case($sformatf("tab%0d", i), tab[i].nburst, tab[i].thr, 100, tab[i].bad_idx,
               tab[i].drop, 1'b0, 1'b1, tab[i].beats, tab[i].cycles, tab[i].err);
    end

    // NBURST=0: DONE two edges after the edge that samples START, with no beat taken.
    NBURST_REG    = 32'd0;
    THROTTLE_REG  = 8'd0;
    START_REG     = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = '0;
    step();
    check("zero done_early", {63'd0, DONE_REG}, 64'd0);
    step();
    check("zero tready_wait", {63'd0, s_axis_tready}, 64'd0);
    step();
    check("zero done",  {63'd0, DONE_REG}, 64'd1);
    check("zero beats", {32'd0, BEATS_REG}, 64'd0);
    START_REG     = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    $display("run zero_timing: done after two edges");

    // Reset in the middle of a run discards everything.
    NBURST_REG   = 32'd2;
    THROTTLE_REG = 8'd0;
    START_REG    = 1'b1;
    step();
    step();
    for (int b = 0; b < 3; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 64'(b);
      step();
    end
    check("midrun beats", {32'd0, BEATS_REG}, 64'd3);
    rst           = 1'b1;
    START_REG     = 1'b0;
    s_axis_tvalid = 1'b0;
    step();
    check("midrst idle",   {63'd0, IDLE_REG}, 64'd1);
    check("midrst done",   {63'd0, DONE_REG}, 64'd0);
    check("midrst tready", {63'd0, s_axis_tready}, 64'd0);
    check("midrst beats",  {32'd0, BEATS_REG}, 64'd0);
    check("midrst cycles", {32'd0, CYCLES_REG}, 64'd0);
    rst = 1'b0;
    step();
    $display("run midrun_reset: counters cleared");

    for (int r = 0; r < 25; r++) begin
      int nb;
      int th;
      int pc;
      int dr;
      nb = $urandom_range(4);
      th = ($urandom_range(3) == 0) ? 0 : $urandom_range(6);
      pc = $urandom_range(100, 40);
      dr = (nb != 0 && $urandom_range(4) == 0) ? $urandom_range(nb * (BL + 1) - 1) : -1;
      run_case($sformatf("rnd%0d", r), nb, th, pc, -1, dr, 1'b1, 1'b0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_bw_sink.md
AXIS_BW_SINK -- requirements
Module: axis_bw_sink

Interface
- REQ-001: The block SHALL have parameter DATA_WIDTH, default 64, giving the AXIS data width in bits.
- REQ-002: The block SHALL have parameter BURST_LENGTH, default 7, giving AXI beats per burst minus 1.
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
- REQ-004: The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005: The block SHALL have port s_axis_tvalid, input, 1 bit: upstream read-data beat valid.
- REQ-006: The block SHALL have port s_axis_tdata, input, DATA_WIDTH bits: upstream read data.
- REQ-007: The block SHALL have port s_axis_tready, output, 1 bit: sink ready.
- REQ-008: The block SHALL have port START_REG, input, 1 bit: level-sensitive run request.
- REQ-009: The block SHALL have port NBURST_REG, input, 32 bits: number of bursts expected.
- REQ-010: The block SHALL have port THROTTLE_REG, input, 8 bits: tready deassert period; 0 means never deassert.
- REQ-011: The block SHALL have port IDLE_REG, output, 1 bit: high in IDLE_ST.
- REQ-012: The block SHALL have port DONE_REG, output, 1 bit: high in DONE_ST.
- REQ-013: The block SHALL have port CYCLES_REG, output, 32 bits: measured cycles.
- REQ-014: The block SHALL have port BEATS_REG, output, 32 bits: accepted beats.
- REQ-015: The block SHALL have port ERR_REG, output, 32 bits: data mismatch count.

Function
- REQ-016: A beat SHALL be accepted in any cycle where s_axis_tvalid and s_axis_tready are both 1, and in no other cycle.
- REQ-017: The state machine SHALL have states IDLE_ST, LATCH_ST, WAIT_ST, RUN_ST and DONE_ST.
- REQ-018: IDLE_ST SHALL go to LATCH_ST when START_REG=1.
- REQ-019: LATCH_ST SHALL register NBURST_REG and THROTTLE_REG, compute expected = NBURST_REG*(BURST_LENGTH+1) with the product truncated to 32 bits, clear all counters, and go to WAIT_ST.
- REQ-020: WAIT_ST SHALL go to DONE_ST if expected=0; otherwise it SHALL go to RUN_ST on the first accepted beat.
- REQ-021: RUN_ST SHALL go to DONE_ST in the cycle the beat making BEATS_REG equal to expected is accepted.
- REQ-022: DONE_ST SHALL go to IDLE_ST when START_REG=0, and the counters SHALL hold their values.
- REQ-023: s_axis_tready SHALL be 1 in WAIT_ST and RUN_ST, except as set by REQ-024, and 0 in IDLE_ST, LATCH_ST and DONE_ST.
- REQ-024: When the latched throttle value T is nonzero, a free-running 8-bit phase counter, cleared in LATCH_ST, SHALL deassert s_axis_tready in every cycle where phase = T, and the phase SHALL wrap from T to 0.
- REQ-025: BEATS_REG SHALL increment by 1 per accepted beat in WAIT_ST and RUN_ST.
- REQ-026: CYCLES_REG SHALL count the cycles from the first accepted beat through the last accepted beat, inclusive, so a single beat yields 1 and back-to-back expected beats yield expected.
- REQ-027: CYCLES_REG and BEATS_REG SHALL saturate at 0xFFFFFFFF and not wrap.
- REQ-028: Beats presented outside WAIT_ST and RUN_ST SHALL be neither accepted nor counted.
- REQ-029: Deasserting START_REG while in WAIT_ST or RUN_ST SHALL send the machine to DONE_ST on the next edge with the counters frozen.

Reset
- REQ-030: rst=1 SHALL force IDLE_ST, s_axis_tready=0, IDLE_REG=1, DONE_REG=0, and CYCLES_REG, BEATS_REG and ERR_REG to 0.
- REQ-031: Reset mid-run SHALL abort the run in the next cycle with no partial result retained.

Configuration
- REQ-032: With AXIS_BW_SINK_CHECK_EN defined, each accepted beat SHALL be compared with the zero-extended value {32'h0, beat index}, and ERR_REG SHALL increment, saturating, on each mismatch.
- REQ-033: Without AXIS_BW_SINK_CHECK_EN defined, no comparator SHALL be built and ERR_REG SHALL be tied to 0.

Verification
- REQ-034: NBURST=4, THROTTLE=0, tvalid held high -> DONE_REG=1, BEATS_REG=32, CYCLES_REG=32.
- REQ-035: NBURST=2, THROTTLE=3, tvalid held high -> tready low in 1 of every 4 cycles, BEATS_REG=16, CYCLES_REG=21.
- REQ-036: NBURST=0 -> DONE_REG=1 two cycles after the START edge, all counters 0, no beat accepted.
- REQ-037: Check enabled, NBURST=1, beats carry 0..7 with beat 5 = 0xFF -> ERR_REG=1; with the check disabled, ERR_REG=0.
- REQ-038: rst pulsed after 3 beats of an NBURST=2 run -> IDLE_REG=1 and counters 0; START cleared mid-run -> DONE with BEATS_REG=3.
